lab03_rr_arbiter8: RTL
======================

LAB03_RR_ARBITER8 -- requirements
Module: lab03_rr_arbiter8

Interface
REQ-001 Parameter: MAX_HOLD, default 16; maximum grant cycles before forced release; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  8  request lines; bit i = requester i; level-sensitive.
REQ-005 done  input  1  release strobe from the granted requester; sampled only in GRANT.
REQ-006 grant  output  8  one-hot grant; at most one bit high; all-zero when no grant.
REQ-007 grant_idx  output  3  binary index of granted requester; grant equals the 3-to-8 decode of grant_idx while grant_valid=1.
REQ-008 grant_valid  output  1  high while any grant is held.
REQ-009 timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-010 FSM states: IDLE, GRANT, GAP; encoding free.
REQ-011 Round-robin pointer ptr, 3 bits: highest priority goes to ptr, then ptr+1, ... ptr+7, modulo 8.
REQ-012 IDLE: if req != 0, select first set bit searching from ptr upward with wrap; register it into grant_idx; next state GRANT.
REQ-013 IDLE with req == 0: stay in IDLE; grant=0, grant_valid=0.
REQ-014 Latency: req asserted in cycle N with arbiter in IDLE -> grant/grant_valid high in cycle N+1.
REQ-015 GRANT: grant = one-hot decode of grant_idx; grant_valid=1; hold counter increments each cycle starting at 1 on the first grant cycle.
REQ-016 GRANT exits to GAP on the first of: done=1; req[grant_idx]=0; hold counter == MAX_HOLD.
REQ-017 done and timeout in the same cycle: treat as a normal release; timeout stays 0.
REQ-018 timeout=1 for exactly the cycle following the GRANT cycle in which the counter reached MAX_HOLD without done or request drop.
REQ-019 On every GRANT exit: ptr <= grant_idx+1 (7 wraps to 0); hold counter cleared.
REQ-020 GAP: grant=0, grant_valid=0 for exactly one cycle; next state IDLE; req ignored in GAP.
REQ-021 Requests changing in GRANT for any line other than grant_idx have no effect on the current grant.
REQ-022 grant_idx holds its last value outside GRANT; consumers qualify it with grant_valid.
REQ-023 All eight requesters asserted continuously: grants issued in order ptr, ptr+1, ..., each once per eight grants; no starvation.

Reset
REQ-024 rst=1 at a rising edge: state<=IDLE, ptr<=0, grant_idx<=0, hold counter<=0, grant=0, grant_valid=0, timeout=0 in the following cycle.
REQ-025 rst overrides all other inputs, including mid-GRANT; the in-flight grant drops next cycle with no timeout pulse and no ptr advance beyond 0.
REQ-026 First arbitration after reset starts search at requester 0.

Verification
REQ-027 Reset then req=8'b0000_0100, done pulsed on 3rd grant cycle -> grant=8'b0000_0100, grant_idx=2 one cycle after req; grant held 3 cycles; 1 GAP cycle; ptr=3.
REQ-028 Reset then req=8'hFF held, done pulsed on 1st grant cycle each time -> grant_idx sequence 0,1,2,...,7,0, each grant separated by one GAP cycle.
REQ-029 ptr=6, req=8'b0100_0001 -> grant_idx=6 first, then 0 (wrap), then 6.
REQ-030 MAX_HOLD=16, req[5] held, done never asserted -> grant held 16 cycles; timeout=1 in the following cycle only; ptr=6.
REQ-031 Granted requester drops req in grant cycle 4 with done=0 -> grant drops next cycle, timeout=0; done and timeout coincident at cycle 16 -> timeout=0.
REQ-032 rst asserted in grant cycle 5 of requester 3 -> grant=0, grant_valid=0, timeout=0 next cycle; with req=8'hFF afterwards, next grant_idx=0.

Source files
------------

// File: rtl/lab03_rr_arbiter8.sv
// lab03_rr_arbiter8 - 8-requester round-robin arbiter with a hold timeout.
//
// A grant is held until the owner pulses done, drops its request, or has
// held it for MAX_HOLD cycles, whichever comes first. Every grant is
// followed by a one-cycle GAP and then an IDLE cycle before the next
// arbitration. Priority rotates to the requester just after the last owner.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   req[7:0]     level-sensitive request lines, bit i = requester i
//   done         release strobe from the current owner (sampled in GRANT)
//   grant[7:0]   one-hot grant, zero when nobody holds it
//   grant_idx    binary index of the owner; qualify with grant_valid
//   grant_valid  high while a grant is held
//   timeout      one-cycle pulse after a forced release
module lab03_rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;
  logic [2:0] pick_idx;
  logic       pick_vld;
  logic       hold_hit;
  logic       rel;
  logic       exit_grant;

  // Rotating priority search. Walk offsets high to low so the smallest
  // offset from ptr is the last writer and therefore wins.
  always_comb begin
    logic [2:0] cand;
    pick_vld = 1'b0;
    pick_idx = ptr;
    cand     = ptr;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign hold_hit   = (hold_cnt == 8'(MAX_HOLD));
  // Voluntary release: owner strobes done or withdraws its request.
  assign rel        = done || !req[grant_idx];
  assign exit_grant = (state == S_GRANT) && (rel || hold_hit);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_vld) state_nxt = S_GRANT;
      S_GRANT: if (rel || hold_hit) state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: owner index, rotation pointer, hold counter, timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 3'd0;
      grant_idx <= 3'd0;
      hold_cnt  <= 8'd0;
      timeout   <= 1'b0;
    end else begin
      // A voluntary release in the same cycle as the limit is not a timeout.
      timeout <= (state == S_GRANT) && hold_hit && !rel;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant_idx <= pick_idx;
            hold_cnt  <= 8'd1;
          end
        end
        S_GRANT: begin
          if (exit_grant) begin
            ptr      <= grant_idx + 3'd1;
            hold_cnt <= 8'd0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    grant_valid = (state == S_GRANT);
    grant       = grant_valid ? (8'd1 << grant_idx) : 8'd0;
  end

endmodule
